hci_starvation_ctrl: RTL and testbench

Per-bank anti-starvation priority controller for the two-input bank arbiter that merges the log-interconnect side (high priority) with the HWPE side (low priority).
- Watches, per memory bank, how long a low-priority request has been pending without a grant.
- After a programmable number of stalled cycles it raises that bank's priority-override bit for the low side, until the low side is served.
- Sits between the interconnect control register file and the bank arbiters; drives their per-bank priority select.

---
 rtl/hci_package.sv | 11 +
 rtl/hci_starvation_bank.sv | 84 ++++++++
 rtl/hci_starvation_ctrl.sv | 74 +++++++
 tb/tb_hci_starvation_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hci_package.sv
// Shared types and defaults for the HCI anti-starvation priority controller.
package hci_package;

  typedef enum logic {
    NORMAL = 1'b0,
    BOOST  = 1'b1
  } hci_starv_state_e;

  localparam int unsigned HCI_STARV_DEFAULT_CNT_W = 8;

endpackage

// File: rtl/hci_starvation_bank.sv
// One bank's starvation watchdog: stall counter plus NORMAL/BOOST FSM.
// boost_evt_o pulses in the cycle whose closing edge enters BOOST.
//
//   state  | meaning
//   NORMAL | low side competes normally, stall cycles are counted
//   BOOST  | low side favoured until it is granted or withdraws
module hci_starvation_bank
  import hci_package::*;
#(
  parameter int unsigned CNT_W = HCI_STARV_DEFAULT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] max_stall_i,
  input  logic             req_low_i,
  input  logic             gnt_low_i,
  output logic             prio_low_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             boost_evt_o
);

  hci_starv_state_e r_state;
  hci_starv_state_e w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_stall;
  logic             w_active;
  logic             w_hit;
  logic             w_boost;

  assign w_stall   = req_low_i & ~gnt_low_i;
  assign w_active  = enable_i & (max_stall_i != '0);
  // One bit wider so the >= compare sees cnt+1 without wrapping.
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_hit     = (w_cnt_inc >= {1'b0, max_stall_i});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= NORMAL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_boost     = 1'b0;
    if (clear_i || !w_active) begin
      w_state_nxt = NORMAL;
    end else begin
      case (r_state)
        NORMAL: begin
          if (w_stall) begin
            if (w_hit) begin
              w_state_nxt = BOOST;
              w_boost     = 1'b1;
            end else if (w_cnt_inc[CNT_W]) begin
              w_cnt_nxt = '1;
            end else begin
              w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
            end
          end
        end
        BOOST: begin
          if (gnt_low_i || !req_low_i) w_state_nxt = NORMAL;
        end
        default: w_state_nxt = NORMAL;
      endcase
    end
  end

  always_comb begin
    prio_low_o  = (r_state == BOOST);
    stall_cnt_o = r_cnt;
    boost_evt_o = w_boost;
  end

endmodule

// File: rtl/hci_starvation_ctrl.sv
// Per-bank anti-starvation priority override for the log-interconnect / HWPE
// bank arbiters, with a saturating global count of boost events.
module hci_starvation_ctrl
  import hci_package::*;
#(
  parameter int unsigned N_MEM = 16,
  parameter int unsigned CNT_W = HCI_STARV_DEFAULT_CNT_W,
  parameter int unsigned EVT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic [CNT_W-1:0]       max_stall_i,
  input  logic [N_MEM-1:0]       req_high_i,
  input  logic [N_MEM-1:0]       req_low_i,
  input  logic [N_MEM-1:0]       gnt_low_i,
  output logic [N_MEM-1:0]       prio_low_o,
  output logic [N_MEM*CNT_W-1:0] stall_cnt_o,
  output logic [EVT_W-1:0]       evt_cnt_o
);

  localparam int unsigned SUM_W = EVT_W + $clog2(N_MEM + 1);
  localparam logic [SUM_W-1:0] EVT_MAX = {{(SUM_W-EVT_W){1'b0}}, {EVT_W{1'b1}}};

  logic [N_MEM-1:0] w_boost_evt;
  logic [SUM_W-1:0] w_pop;
  logic [SUM_W-1:0] w_evt_sum;
  logic [EVT_W-1:0] r_evt_cnt;
  logic             w_unused_req_high;

  // High-side requests do not steer the override; kept on the port for visibility.
  assign w_unused_req_high = ^req_high_i;

  for (genvar gi = 0; gi < N_MEM; gi++) begin : g_bank
    hci_starvation_bank #(
      .CNT_W (CNT_W)
    ) u_bank (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (clear_i),
      .enable_i    (enable_i),
      .max_stall_i (max_stall_i),
      .req_low_i   (req_low_i[gi]),
      .gnt_low_i   (gnt_low_i[gi]),
      .prio_low_o  (prio_low_o[gi]),
      .stall_cnt_o (stall_cnt_o[gi*CNT_W +: CNT_W]),
      .boost_evt_o (w_boost_evt[gi])
    );
  end

  always_comb begin
    w_pop = '0;
    for (int ii = 0; ii < N_MEM; ii++) begin
      w_pop = w_pop + {{(SUM_W-1){1'b0}}, w_boost_evt[ii]};
    end
    w_evt_sum = {{(SUM_W-EVT_W){1'b0}}, r_evt_cnt} + w_pop;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_evt_cnt <= '0;
    end else if (clear_i) begin
      r_evt_cnt <= '0;
    end else if (w_evt_sum > EVT_MAX) begin
      r_evt_cnt <= '1;
    end else begin
      r_evt_cnt <= w_evt_sum[EVT_W-1:0];
    end
  end

  assign evt_cnt_o = r_evt_cnt;

endmodule

// File: tb/tb_hci_starvation_ctrl.sv
// Directed bench: default-size controller plus a CNT_W=2/EVT_W=4 instance for saturation.
module tb_hci_starvation_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clear_i;
  logic        enable_i;
  logic [7:0]  max_stall;
  logic [1:0]  max_stall_s;
  logic [15:0] req_high;
  logic [15:0] req_low;
  logic [15:0] gnt_low;

  logic [15:0]  prio;
  logic [127:0] cnt;
  logic [31:0]  evt;
  logic [15:0]  prio_s;
  logic [31:0]  cnt_s;
  logic [3:0]   evt_s;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] seen_prio;
  logic [7:0]  seen_cnt;

  always #5 clk_i = ~clk_i;

  hci_starvation_ctrl #(.N_MEM(16), .CNT_W(8), .EVT_W(32)) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .enable_i    (enable_i),
    .max_stall_i (max_stall),
    .req_high_i  (req_high),
    .req_low_i   (req_low),
    .gnt_low_i   (gnt_low),
    .prio_low_o  (prio),
    .stall_cnt_o (cnt),
    .evt_cnt_o   (evt)
  );

  hci_starvation_ctrl #(.N_MEM(16), .CNT_W(2), .EVT_W(4)) u_dut_small (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .enable_i    (enable_i),
    .max_stall_i (max_stall_s),
    .req_high_i  (req_high),
    .req_low_i   (req_low),
    .gnt_low_i   (gnt_low),
    .prio_low_o  (prio_s),
    .stall_cnt_o (cnt_s),
    .evt_cnt_o   (evt_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] bcnt(input int b);
    return cnt[b*8 +: 8];
  endfunction

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; enable_i = 1'b1;
    max_stall = 8'd0; max_stall_s = 2'd0;
    req_high = 16'h0; req_low = 16'h0; gnt_low = 16'h0;
    step(); step();
    rst_i = 1'b0;
    step();
    check_eq("rst_prio", 32'(prio), 32'h0);
    check_eq("rst_cnt0", 32'(bcnt(0)), 32'h0);
    check_eq("rst_evt", evt, 32'h0);

    // async reset while bank 3 is boosted
    max_stall = 8'd2; req_low = 16'h0008; req_high = 16'h0008;
    step(); step();
    check_eq("b3_boost", 32'(prio), 32'h0008);
    check_eq("b3_evt", evt, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check_eq("async_prio", 32'(prio), 32'h0);
    check_eq("async_cnt3", 32'(bcnt(3)), 32'h0);
    check_eq("async_evt", evt, 32'h0);
    rst_i = 1'b0; req_low = 16'h0; req_high = 16'h0;
    step();

    // threshold 4 on bank 0
    max_stall = 8'd4; req_low = 16'h0001; req_high = 16'h0001;
    step(); check_eq("thr_cnt1", 32'(bcnt(0)), 32'd1);
    step(); check_eq("thr_cnt2", 32'(bcnt(0)), 32'd2);
    step(); check_eq("thr_cnt3", 32'(bcnt(0)), 32'd3);
    check_eq("thr_prio_c3", 32'(prio), 32'h0);
    step();
    check_eq("thr_prio_c4", 32'(prio), 32'h0001);
    check_eq("thr_cnt_c4", 32'(bcnt(0)), 32'd0);
    check_eq("thr_evt_c4", evt, 32'd1);
    step();
    step();
    check_eq("thr_prio_c6", 32'(prio), 32'h0001);
    gnt_low = 16'h0001;
    step();
    check_eq("thr_prio_c7", 32'(prio), 32'h0);
    check_eq("thr_evt_c7", evt, 32'd1);
    gnt_low = 16'h0; req_low = 16'h0; req_high = 16'h0;
    step();

    // interrupted stall
    clear_i = 1'b1; step(); clear_i = 1'b0;
    check_eq("clr_evt", evt, 32'h0);
    req_low = 16'h0001;
    step(); step(); step();
    check_eq("int_cnt3a", 32'(bcnt(0)), 32'd3);
    gnt_low = 16'h0001;
    step();
    check_eq("int_cnt_gnt", 32'(bcnt(0)), 32'd0);
    gnt_low = 16'h0;
    step(); step(); step();
    check_eq("int_cnt3b", 32'(bcnt(0)), 32'd3);
    check_eq("int_prio", 32'(prio), 32'h0);
    check_eq("int_evt", evt, 32'h0);
    req_low = 16'h0;
    step();
    check_eq("int_cnt_wd", 32'(bcnt(0)), 32'd0);

    // max_stall = 0 never overrides
    max_stall = 8'd0; req_low = 16'h0001;
    seen_prio = 16'h0; seen_cnt = 8'h0;
    for (int i = 0; i < 300; i++) begin
      step();
      seen_prio = seen_prio | prio;
      seen_cnt  = seen_cnt | bcnt(0);
    end
    check_eq("dis_prio", 32'(seen_prio), 32'h0);
    check_eq("dis_cnt", 32'(seen_cnt), 32'h0);

    // enable dropped during BOOST
    max_stall = 8'd2;
    step(); step();
    check_eq("en_boost", 32'(prio), 32'h0001);
    enable_i = 1'b0;
    step();
    check_eq("en_off_prio", 32'(prio), 32'h0);
    check_eq("en_off_cnt", 32'(bcnt(0)), 32'd0);
    check_eq("en_off_evt", evt, 32'd1);
    enable_i = 1'b1; req_low = 16'h0;
    step();

    // banks 1,5,9 with threshold lowered mid-count
    clear_i = 1'b1; step(); clear_i = 1'b0;
    max_stall = 8'd10; req_low = 16'h0222;
    for (int i = 0; i < 5; i++) step();
    check_eq("mb_cnt5", 32'(bcnt(5)), 32'd5);
    check_eq("mb_cnt9", 32'(bcnt(9)), 32'd5);
    check_eq("mb_prio_pre", 32'(prio), 32'h0);
    max_stall = 8'd2;
    step();
    check_eq("mb_prio", 32'(prio), 32'h0222);
    check_eq("mb_evt", evt, 32'd3);
    req_low = 16'h0;
    step();
    check_eq("mb_release", 32'(prio), 32'h0);

    // small instance: CNT_W=2 threshold 3, EVT_W=4 saturation
    max_stall = 8'd0;
    clear_i = 1'b1; step(); clear_i = 1'b0;
    max_stall_s = 2'd3; req_low = 16'h0001;
    step(); check_eq("s_cnt1", 32'(cnt_s[1:0]), 32'd1);
    step(); check_eq("s_cnt2", 32'(cnt_s[1:0]), 32'd2);
    check_eq("s_prio_pre", 32'(prio_s), 32'h0);
    step();
    check_eq("s_prio", 32'(prio_s), 32'h0001);
    check_eq("s_evt1", 32'(evt_s), 32'd1);
    max_stall_s = 2'd1;
    req_low = 16'h0;
    step();
    for (int i = 2; i <= 20; i++) begin
      req_low = 16'h0001;
      step();
      if (i == 14) check_eq("s_evt14", 32'(evt_s), 32'd14);
      if (i == 15) check_eq("s_evt15", 32'(evt_s), 32'd15);
      req_low = 16'h0;
      step();
    end
    check_eq("s_evt_sat", 32'(evt_s), 32'd15);
    check_eq("main_idle_evt", evt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
